// File: rtl/screen_sequencer_pkg.sv
// rtl/screen_sequencer_pkg.sv - shared screen states, select encodings and pixel type
package screen_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_RESTART,
        ST_PLAY,
        ST_WIN,
        ST_LOSE,
        ST_OVER
    } screen_state_t;

    localparam logic [1:0] SEL_GAME = 2'd0;
    localparam logic [1:0] SEL_WIN  = 2'd1;
    localparam logic [1:0] SEL_LOSE = 2'd2;
    localparam logic [1:0] SEL_OVER = 2'd3;

    // {r[3:0], g[3:0], b[3:0]}
    typedef logic [11:0] rgb_t;

    // RESTART shows the game screen so the freshly reset playfield is visible.
    function automatic logic [1:0] sel_of(screen_state_t s);
        case (s)
            ST_WIN:  return SEL_WIN;
            ST_LOSE: return SEL_LOSE;
            ST_OVER: return SEL_OVER;
            default: return SEL_GAME;
        endcase
    endfunction

endpackage

// File: rtl/button_edge_sync.sv
// rtl/button_edge_sync.sv - two-flop synchroniser with one-cycle rising-edge pulse
module button_edge_sync (
    input  logic clock,   // destination clock
    input  logic reset,   // asynchronous, active-low
    input  logic button,  // raw asynchronous button, active-high
    output logic press    // one-cycle pulse per synchronised rising edge
);

    logic sync1;
    logic sync2;
    logic prev;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b0;
        end else begin
            sync1 <= button;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign press = sync2 & ~prev;

endmodule

// File: rtl/screen_sequencer.sv
// rtl/screen_sequencer.sv - game/win/lose/over screen sequencer with lives and registered pixel mux
module screen_sequencer
    import screen_sequencer_pkg::*;
#(
    parameter int HOLD_FRAMES = 120,  // frames a WIN/LOSE screen is held
    parameter int START_LIVES = 3     // 1..7
) (
    input  logic        vga_clock,    // single clock
    input  logic        reset,        // asynchronous, active-low
    input  logic        frame_start,  // pulse at row 0, column 0
    input  logic        jump_button,  // raw asynchronous button
    input  logic        win_event,    // player reached goal
    input  logic        lose_event,   // player died
    input  logic [11:0] game_rgb,
    input  logic [11:0] win_rgb,
    input  logic [11:0] lose_rgb,
    output logic [3:0]  vga_red,
    output logic [3:0]  vga_green,
    output logic [3:0]  vga_blue,
    output logic [1:0]  screen_select,
    output logic        game_reset,
    output logic        game_enable,
    output logic [2:0]  lives
);

    localparam int HOLD_W = (HOLD_FRAMES > 0) ? $clog2(HOLD_FRAMES + 1) : 1;

    screen_state_t     state;
    screen_state_t     state_nxt;
    logic [2:0]        lives_nxt;
    logic [HOLD_W-1:0] hold;
    logic              hold_done;
    logic              restart_armed;
    logic              win_pend;
    logic              lose_pend;
    logic              press_pend;
    logic              press;
    logic              accept_press;
    logic              press_now;
    logic              state_chg;
    rgb_t              pix_sel;
    rgb_t              pix_q;

    button_edge_sync u_jump_sync (
        .clock  (vga_clock),
        .reset  (reset),
        .button (jump_button),
        .press  (press)
    );

    assign hold_done    = (hold == HOLD_W'(HOLD_FRAMES));
    // Presses outside these windows are dropped rather than queued.
    assign accept_press = ((state == ST_WIN) && hold_done) || (state == ST_OVER);
    assign press_now    = press_pend || (press && accept_press);
    assign state_chg    = (state_nxt != state);

    always_comb begin
        state_nxt = state;
        lives_nxt = lives;
        if (frame_start) begin
            case (state)
                // Only leave RESTART once a whole frame has been spent there.
                ST_RESTART: if (restart_armed) state_nxt = ST_PLAY;
                ST_PLAY: begin
                    if (win_pend || win_event) begin
                        state_nxt = ST_WIN;
                    end else if (lose_pend || lose_event) begin
                        state_nxt = ST_LOSE;
                        if (lives != 3'd0) lives_nxt = lives - 3'd1;
                    end
                end
                ST_WIN: begin
                    if (hold_done && press_now) begin
                        state_nxt = ST_RESTART;
                        lives_nxt = 3'(START_LIVES);
                    end
                end
                ST_LOSE: begin
                    if (hold_done) state_nxt = (lives == 3'd0) ? ST_OVER : ST_RESTART;
                end
                ST_OVER: begin
                    if (press_now) begin
                        state_nxt = ST_RESTART;
                        lives_nxt = 3'(START_LIVES);
                    end
                end
                default: state_nxt = ST_RESTART;
            endcase
        end
    end

    // Pixel source follows the registered screen_select, which only moves at
    // frame_start, so one frame is always drawn from a single source.
    always_comb begin
        case (screen_select)
            SEL_WIN:            pix_sel = win_rgb;
            SEL_LOSE, SEL_OVER: pix_sel = lose_rgb;
            default:            pix_sel = game_rgb;
        endcase
    end

    always_ff @(posedge vga_clock or negedge reset) begin
        if (!reset) begin
            state         <= ST_RESTART;
            lives         <= 3'(START_LIVES);
            hold          <= '0;
            restart_armed <= 1'b0;
            win_pend      <= 1'b0;
            lose_pend     <= 1'b0;
            press_pend    <= 1'b0;
            screen_select <= SEL_GAME;
            game_reset    <= 1'b1;
            game_enable   <= 1'b0;
            pix_q         <= '0;
        end else begin
            state         <= state_nxt;
            lives         <= lives_nxt;
            // Entry into RESTART always happens on frame_start; after reset the
            // first frame_start arms it so the reset frame is a full one.
            restart_armed <= (state_nxt == ST_RESTART) && (restart_armed || frame_start);

            if (state_chg) begin
                hold <= '0;
            end else if (frame_start && (state == ST_WIN || state == ST_LOSE) && !hold_done) begin
                hold <= hold + 1'b1;
            end

            if (state_chg) begin
                win_pend  <= 1'b0;
                lose_pend <= 1'b0;
            end else if (state == ST_PLAY) begin
                if (win_event)  win_pend  <= 1'b1;
                if (lose_event) lose_pend <= 1'b1;
            end

            if (frame_start) begin
                press_pend <= 1'b0;
            end else if (press && accept_press) begin
                press_pend <= 1'b1;
            end

            screen_select <= sel_of(state_nxt);
            game_reset    <= (state_nxt == ST_RESTART);
            game_enable   <= (state_nxt == ST_PLAY);
            pix_q         <= pix_sel;
        end
    end

    assign vga_red   = pix_q[11:8];
    assign vga_green = pix_q[7:4];
    assign vga_blue  = pix_q[3:0];

endmodule

// File: doc/screen_sequencer.md
SCREEN_SEQUENCER -- requirements
Module: screen_sequencer

Interface
REQ-001 Parameter HOLD_FRAMES, default 120, frames a WIN/LOSE screen is held before restart is allowed.
REQ-002 Parameter START_LIVES, default 3, lives loaded at reset and on new game; range 1..7.
REQ-003 vga_clock  input  1  single clock for all logic.
REQ-004 reset  input  1  asynchronous, active-low.
REQ-005 frame_start  input  1  one-cycle pulse at row 0, column 0 of each frame.
REQ-006 jump_button  input  1  raw asynchronous button, active-high.
REQ-007 win_event  input  1  level or pulse from game logic: player reached goal.
REQ-008 lose_event  input  1  level or pulse from game logic: player died.
REQ-009 game_rgb, win_rgb, lose_rgb  input  12 each  {r,g,b} 4 bits per channel from the three drawers.
REQ-010 vga_red, vga_green, vga_blue  output  4 each  selected, registered pixel colour.
REQ-011 screen_select  output  2  current screen: 0 GAME, 1 WIN, 2 LOSE, 3 OVER.
REQ-012 game_reset  output  1  held high for exactly one full frame when a game (re)starts.
REQ-013 game_enable  output  1  high only in PLAY state with game_reset low.
REQ-014 lives  output  3  remaining lives.

Function
REQ-015 States: RESTART, PLAY, WIN, LOSE, OVER; state changes take effect only on a cycle with frame_start high.
REQ-016 jump_button passes a two-flop synchroniser then a rising-edge detector; a press is latched as pending until consumed at the next frame_start.
REQ-017 win_event/lose_event are latched as pending when high in PLAY; pending cleared on every state change.
REQ-018 RESTART -> PLAY after one frame; game_reset high for all cycles in RESTART.
REQ-019 PLAY -> WIN on pending win; PLAY -> LOSE on pending lose, lives decremented by 1 on that transition.
REQ-020 Win and lose pending in same frame: win has priority, lives unchanged.
REQ-021 Entering WIN/LOSE clears a hold counter; it increments per frame_start, saturating at HOLD_FRAMES.
REQ-022 WIN -> RESTART when hold counter equals HOLD_FRAMES and a press is pending; lives reloaded to START_LIVES.
REQ-023 LOSE -> RESTART when hold counter equals HOLD_FRAMES and lives > 0 (no press needed); LOSE -> OVER when it equals HOLD_FRAMES and lives == 0.
REQ-024 OVER -> RESTART on pending press; lives reloaded to START_LIVES.
REQ-025 Presses before hold expiry are discarded, not stored.
REQ-026 Lives never underflow: decrement at 0 is suppressed.
REQ-027 RGB mux: GAME and RESTART select game_rgb, WIN selects win_rgb, LOSE and OVER select lose_rgb; output registered, latency 1 cycle.
REQ-028 Screen selection is updated only with state at frame_start, so a frame never mixes sources.

Reset
REQ-029 On reset low: state RESTART, lives START_LIVES, hold counter 0, all pendings and synchroniser flops 0, RGB outputs 0, screen_select 0, game_reset 1, game_enable 0.
REQ-030 Reset asserted mid-frame or mid-hold takes effect immediately; after release the sequence starts at RESTART.

Structure
REQ-031 Shared package holds the screen-state enum, screen_select encodings, and the 12-bit rgb typedef.
REQ-032 One sub-module button_edge_sync (synchroniser plus rising-edge pulse), reusable for other buttons.

Verification
REQ-033 Release reset, run 2 frames -> game_reset high for frame 0 only, game_enable high from frame 1, lives=3.
REQ-034 In PLAY pulse win_event mid-frame -> screen_select=1 at next frame_start; vga_* equal win_rgb one cycle later; press at frame 50 ignored; press after frame 120 -> RESTART then PLAY.
REQ-035 Three lose_event cycles with no presses -> lives 2,1,0; third goes LOSE then OVER after 120 frames; press -> RESTART, lives=3.
REQ-036 win_event and lose_event in same frame -> WIN, lives unchanged.
REQ-037 Assert reset at frame 60 of WIN hold -> outputs at reset values immediately; after release RESTART, lives=3.
REQ-038 Button glitch shorter than 2 cycles and a held button -> at most one press registered per rising edge.
